// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// state encoding and the instruction-class record produced by the decoder.
package control_unit_pkg;

    localparam int STATE_W = 4;

    localparam logic [4:0] ADD_OP  = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b10110;
    localparam logic [4:0] OP_MFLO = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_e;

    typedef struct packed {
        logic alu3;
        logic imm;
        logic muldiv;
        logic unary;
        logic mfx;
        logic ld;
        logic ldi;
        logic st;
        logic nop;
        logic halt;
    } instr_class_t;

    // Immediate forms reuse the register-form ALU codes.
    function automatic logic [4:0] imm_alu_code(input logic [4:0] op);
        case (op)
            OP_ADDI: imm_alu_code = ADD_OP;
            OP_ANDI: imm_alu_code = ALU_AND;
            OP_ORI:  imm_alu_code = ALU_OR;
            default: imm_alu_code = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier: IR[31:27] -> one-hot instruction class.
// Anything not recognised is treated as nop.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic [4:0]   op_i,
    output instr_class_t cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i) inside
            OP_LD:             cls_o.ld     = 1'b1;
            OP_LDI:            cls_o.ldi    = 1'b1;
            OP_ST:             cls_o.st     = 1'b1;
            [OP_ADD:OP_ROL]:   cls_o.alu3   = 1'b1;
            [OP_ADDI:OP_ORI]:  cls_o.imm    = 1'b1;
            OP_MUL, OP_DIV:    cls_o.muldiv = 1'b1;
            OP_NEG, OP_NOT:    cls_o.unary  = 1'b1;
            OP_MFHI, OP_MFLO:  cls_o.mfx    = 1'b1;
            OP_HALT:           cls_o.halt   = 1'b1;
            default:           cls_o.nop    = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: state register, next-state logic and per-state
// strobe decode. Define CU_MEM_WAIT_EN to add mem_ready wait states.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
`ifdef CU_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout,
    output logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output logic Gra, Grb, Grc, Rin, Rout,
    output logic IncPC, Read, Write,
    output logic [4:0] opcode,
    output logic Run,
    output logic [STATE_W-1:0] dbg_state_o
);

    state_e       state_q, state_d;
    instr_class_t cls;
    logic         mem_wait;
    logic [4:0]   op;
    logic         unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign dbg_state_o = state_q;

`ifdef CU_MEM_WAIT_EN
    assign mem_wait = ~mem_ready;
`else
    assign mem_wait = 1'b0;
`endif

    control_unit_decode u_decode (
        .op_i  (op),
        .cls_o (cls)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_T0;
            S_T0:     state_d = Stop ? S_HALTED : S_T1;
            S_T1:     state_d = mem_wait ? S_T1 : S_T2;
            S_T2:     state_d = cls.halt ? S_HALTED : (cls.nop ? S_T0 : S_T3);
            S_T3:     state_d = cls.mfx ? S_T0 : S_T4;
            S_T4:     state_d = cls.unary ? S_T0 : S_T5;
            S_T5:     state_d = (cls.alu3 | cls.imm | cls.ldi) ? S_T0 : S_T6;
            S_T6: begin
                if (cls.muldiv)                  state_d = S_T0;
                else if (cls.ld && mem_wait)     state_d = S_T6;
                else                             state_d = S_T7;
            end
            S_T7:     state_d = (cls.st && mem_wait) ? S_T7 : S_T0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin}              = '0;
        {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write}                = '0;
        opcode = 5'b00000;
        Run    = (state_q != S_RESET) && (state_q != S_HALTED);
        case (state_q)
            S_T0: if (!Stop) {PCout, MARin, IncPC, Zin} = '1;
            S_T1: {Zlowout, PCin, Read, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                if (cls.alu3 | cls.imm)          {Grb, Rout, Yin} = '1;
                if (cls.muldiv)                  {Gra, Rout, Yin} = '1;
                if (cls.ld | cls.ldi | cls.st)   {Grb, BAout, Yin} = '1;
                if (cls.unary) begin
                    {Grb, Rout, Zin} = '1;
                    opcode = op;
                end
                if (cls.mfx) begin
                    HIout = (op == OP_MFHI);
                    LOout = (op == OP_MFLO);
                    {Gra, Rin} = '1;
                end
            end
            S_T4: begin
                if (cls.alu3 | cls.muldiv) begin
                    Grc = cls.alu3;
                    Grb = cls.muldiv;
                    {Rout, Zin} = '1;
                    opcode = op;
                end
                if (cls.imm) begin
                    {Cout, Zin} = '1;
                    opcode = imm_alu_code(op);
                end
                if (cls.ld | cls.ldi | cls.st) begin
                    {Cout, Zin} = '1;
                    opcode = ADD_OP;
                end
                if (cls.unary) {Zlowout, Gra, Rin} = '1;
            end
            S_T5: begin
                if (cls.alu3 | cls.imm | cls.ldi) {Zlowout, Gra, Rin} = '1;
                if (cls.muldiv)                   {Zlowout, LOin} = '1;
                if (cls.ld | cls.st)              {Zlowout, MARin} = '1;
            end
            S_T6: begin
                if (cls.muldiv) {Zhighout, HIin} = '1;
                if (cls.ld)     {Read, MDRin} = '1;
                if (cls.st)     {Gra, Rout, MDRin} = '1;
            end
            S_T7: begin
                if (cls.ld) {MDRout, Gra, Rin} = '1;
                if (cls.st) Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; strobe sequences are written
// out by hand per instruction and consumed from an expected queue.
module tb_control_unit;

    localparam int W = 30;

    // Strobe bit positions in the observed vector {strobes[23:0], opcode, Run}
    localparam logic [23:0] M_PCOUT    = 24'd1 << 23;
    localparam logic [23:0] M_ZHIGHOUT = 24'd1 << 22;
    localparam logic [23:0] M_ZLOWOUT  = 24'd1 << 21;
    localparam logic [23:0] M_MDROUT   = 24'd1 << 20;
    localparam logic [23:0] M_HIOUT    = 24'd1 << 19;
    localparam logic [23:0] M_LOOUT    = 24'd1 << 18;
    localparam logic [23:0] M_COUT     = 24'd1 << 17;
    localparam logic [23:0] M_BAOUT    = 24'd1 << 16;
    localparam logic [23:0] M_PCIN     = 24'd1 << 15;
    localparam logic [23:0] M_IRIN     = 24'd1 << 14;
    localparam logic [23:0] M_MARIN    = 24'd1 << 13;
    localparam logic [23:0] M_MDRIN    = 24'd1 << 12;
    localparam logic [23:0] M_YIN      = 24'd1 << 11;
    localparam logic [23:0] M_ZIN      = 24'd1 << 10;
    localparam logic [23:0] M_HIIN     = 24'd1 << 9;
    localparam logic [23:0] M_LOIN     = 24'd1 << 8;
    localparam logic [23:0] M_GRA      = 24'd1 << 7;
    localparam logic [23:0] M_GRB      = 24'd1 << 6;
    localparam logic [23:0] M_GRC      = 24'd1 << 5;
    localparam logic [23:0] M_RIN      = 24'd1 << 4;
    localparam logic [23:0] M_ROUT     = 24'd1 << 3;
    localparam logic [23:0] M_INCPC    = 24'd1 << 2;
    localparam logic [23:0] M_READ     = 24'd1 << 1;
    localparam logic [23:0] M_WRITE    = 24'd1 << 0;

    localparam logic [W-1:0] V_ZERO = '0;
    localparam logic [W-1:0] V_T0 = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b00000, 1'b1};
    localparam logic [W-1:0] V_T1 = {M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b00000, 1'b1};
    localparam logic [W-1:0] V_T2 = {M_MDROUT | M_IRIN, 5'b00000, 1'b1};

    logic        Clock, clear, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
    logic [4:0] opcode;
    logic Run;
    logic [3:0] dbg_state;
`ifdef CU_MEM_WAIT_EN
    logic mem_ready;
`endif

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    control_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
`ifdef CU_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .opcode(opcode), .Run(Run), .dbg_state_o(dbg_state)
    );

    assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout,
                  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                  Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, opcode, Run};

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ev(input logic [23:0] s, input logic [4:0] op);
        return {s, op, 1'b1};
    endfunction

    // Check the current state's outputs on the falling edge, then step one cycle.
    task automatic expect_v(input string tag, input logic [W-1:0] e);
        @(negedge Clock);
        checks++;
        assert (obs === e) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, e);
            $error("check %s", tag);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic push_fetch();
        exp_q.push_back(V_T0);
        exp_q.push_back(V_T1);
        exp_q.push_back(V_T2);
    endtask

    task automatic drain(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            expect_v(tag, e);
        end
    endtask

    initial begin
        clear = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h0;
`ifdef CU_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge Clock);
        #1;
        expect_v("reset_hold", V_ZERO);
        clear = 1'b0;
        expect_v("reset_release", V_ZERO);

        // and R1,R2,R3
        IR = 32'h28918000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_ROUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_GRC | M_ROUT | M_ZIN, 5'b00101));
        exp_q.push_back(ev(M_ZLOWOUT | M_GRA | M_RIN, 5'b00000));
        drain("and");

        // neg R0,R1
        IR = 32'h88080000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_ROUT | M_ZIN, 5'b10001));
        exp_q.push_back(ev(M_ZLOWOUT | M_GRA | M_RIN, 5'b00000));
        drain("neg");

        // mul
        IR = 32'h78000000;
        push_fetch();
        exp_q.push_back(ev(M_GRA | M_ROUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_GRB | M_ROUT | M_ZIN, 5'b01111));
        exp_q.push_back(ev(M_ZLOWOUT | M_LOIN, 5'b00000));
        exp_q.push_back(ev(M_ZHIGHOUT | M_HIIN, 5'b00000));
        drain("mul");

        // st
        IR = 32'h10000000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_BAOUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_COUT | M_ZIN, 5'b00011));
        exp_q.push_back(ev(M_ZLOWOUT | M_MARIN, 5'b00000));
        exp_q.push_back(ev(M_GRA | M_ROUT | M_MDRIN, 5'b00000));
        exp_q.push_back(ev(M_WRITE, 5'b00000));
        drain("st");

        // ldi
        IR = 32'h08000000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_BAOUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_COUT | M_ZIN, 5'b00011));
        exp_q.push_back(ev(M_ZLOWOUT | M_GRA | M_RIN, 5'b00000));
        drain("ldi");

        // ori uses the OR ALU code
        IR = 32'h70000000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_ROUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_COUT | M_ZIN, 5'b00110));
        exp_q.push_back(ev(M_ZLOWOUT | M_GRA | M_RIN, 5'b00000));
        drain("ori");

        // mfhi
        IR = 32'hB0000000;
        push_fetch();
        exp_q.push_back(ev(M_HIOUT | M_GRA | M_RIN, 5'b00000));
        drain("mfhi");

        // mflo
        IR = 32'hB8000000;
        push_fetch();
        exp_q.push_back(ev(M_LOOUT | M_GRA | M_RIN, 5'b00000));
        drain("mflo");

        // undefined opcode 11111 behaves as nop; Stop outside T0 is ignored
        IR = 32'hF8000000;
        expect_v("undef_t0", V_T0);
        Stop = 1'b1;
        expect_v("undef_t1", V_T1);
        expect_v("undef_t2", V_T2);
        Stop = 1'b0;
        expect_v("undef_back_t0", V_T0);
        expect_v("undef_t1b", V_T1);
        expect_v("undef_t2b", V_T2);

        // Stop in T0: no strobes that cycle, then HALTED
        Stop = 1'b1;
        @(negedge Clock);
        checks++;
        assert (obs[W-1:1] === 29'b0) else begin
            errors++;
            $display("FAIL stop_t0: observed=%h expected strobes zero", obs);
            $error("check stop_t0");
        end
        @(posedge Clock);
        #1;
        Stop = 1'b0;
        for (int i = 0; i < 10; i++) expect_v("halted_stop", V_ZERO);
        clear = 1'b1;
        expect_v("halted_clear", V_ZERO);
        clear = 1'b0;
        expect_v("reset_after_halt", V_ZERO);

        // halt opcode
        IR = 32'hD8000000;
        push_fetch();
        repeat (3) exp_q.push_back(V_ZERO);
        drain("halt_op");
        clear = 1'b1;
        expect_v("halt_op_clear", V_ZERO);
        clear = 1'b0;
        expect_v("reset_after_halt_op", V_ZERO);

        // ld, then clear while in T6
        IR = 32'h00000000;
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_BAOUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_COUT | M_ZIN, 5'b00011));
        exp_q.push_back(ev(M_ZLOWOUT | M_MARIN, 5'b00000));
        drain("ld");
        clear = 1'b1;
        expect_v("ld_t6", ev(M_READ | M_MDRIN, 5'b00000));
        expect_v("ld_clear_reset", V_ZERO);
        clear = 1'b0;
        expect_v("ld_clear_reset2", V_ZERO);

        // full ld
        push_fetch();
        exp_q.push_back(ev(M_GRB | M_BAOUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_COUT | M_ZIN, 5'b00011));
        exp_q.push_back(ev(M_ZLOWOUT | M_MARIN, 5'b00000));
        exp_q.push_back(ev(M_READ | M_MDRIN, 5'b00000));
        exp_q.push_back(ev(M_MDROUT | M_GRA | M_RIN, 5'b00000));
        drain("ld_full");

`ifdef CU_MEM_WAIT_EN
        // T1 held three extra cycles while memory is busy
        IR = 32'h28918000;
        mem_ready = 1'b0;
        expect_v("wait_t0", V_T0);
        for (int i = 0; i < 3; i++) expect_v("wait_t1_hold", V_T1);
        mem_ready = 1'b1;
        expect_v("wait_t1_last", V_T1);
        expect_v("wait_t2", V_T2);
        exp_q.push_back(ev(M_GRB | M_ROUT | M_YIN, 5'b00000));
        exp_q.push_back(ev(M_GRC | M_ROUT | M_ZIN, 5'b00101));
        exp_q.push_back(ev(M_ZLOWOUT | M_GRA | M_RIN, 5'b00000));
        drain("wait_and");
`endif

        expect_v("final_t0", V_T0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
